ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
// AHB-Lite SRAM slave. Sits directly upstream of the slave-to-master response mux.
// Receives the decoder's select for its slot and the master address/control/write data.
// Drives Hrdata_S/Hresp_S/Hreadyout_S for that slot.
// Provides a word-addressed memory with byte/halfword/word writes, programmable wait states
// and the two-cycle AHB ERROR response.
// PARAMETERS
// DATA_WIDTH   32   data bus width; only 32 is supported
// ADDR_WIDTH   32   Haddr width
// MEM_DEPTH    256  number of 32-bit words; Haddr[1:0] selects the byte, the word index is Haddr>>2
// WAIT_STATES  1    Hreadyout-low cycles inserted per OKAY data phase (0..15)
// PORTS
// Hclk       in   1           bus clock, all state on rising edge
// Hresetn    in   1           asynchronous active-low reset
// Hsel       in   1           slot select from the address decoder
// Haddr      in   ADDR_WIDTH  address-phase address
// Htrans     in   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// Hwrite     in   1           1 = write
// Hsize      in   3           0 byte, 1 halfword, 2 word; >2 is illegal
// Hwdata     in   DATA_WIDTH  write data, valid in the data phase
// Hready     in   1           global ready fed back from the response mux
// Hrdata     out  DATA_WIDTH  read data, slot input of the response mux
// Hresp      out  2           00 OKAY, 01 ERROR
// Hreadyout  out  1           slave ready, slot input of the response mux
// BEHAVIOUR
// - Reset (asynchronous, any state) forces:
//   - state IDLE, wait counter 0, pending data phase cleared;
//   - Hreadyout=1, Hresp=00, Hrdata=0.
//   - Memory contents are not reset.
// - Accept condition, sampled at the rising edge: Hsel & Hready & Htrans[1].
//   - When this is true, register addr/write/size into the data-phase registers.
//   - IDLE and BUSY, or any address phase with Hsel=0 or Hready=0: no transfer; the next
//     cycle is zero-wait OKAY.
// - Error check on accept. An access is illegal if any of the following holds:
//   - Hsize>2;
//   - word index >= MEM_DEPTH;
//   - misaligned: Hsize=1 with Haddr[0]!=0, or Hsize=2 with Haddr[1:0]!=0.
// - FSM states:
//   - IDLE: Hreadyout=1, Hresp=00.
//     - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES.
//     - Legal accept with WAIT_STATES=0 -> DATA.
//     - Illegal accept -> ERR1.
//   - WAIT: Hreadyout=0, Hresp=00.
//     - Counter decrements each cycle; at 1 -> DATA.
//     - New address phases are not accepted, because Hready=0.
//   - DATA: Hreadyout=1, Hresp=00. The transfer completes in this cycle.
//     - Read: Hrdata = mem[word index], full 32-bit word on all lanes.
//     - Write: at the closing edge, Hwdata lanes selected by size/Haddr[1:0] are written
//       (byte-lane enables, little-endian).
//     - The same edge may accept the next transfer and go to WAIT, DATA or ERR1;
//       otherwise -> IDLE.
//   - ERR1: Hreadyout=0, Hresp=01 -> ERR2.
//   - ERR2: Hreadyout=1, Hresp=01 -> IDLE, or accept the next transfer as from DATA.
//     - Memory is never written for an ERROR transfer.
// - Hrdata is 0 in every cycle except a DATA cycle of a read.
// - Latency:
//   - an OKAY transfer completes WAIT_STATES+1 cycles after the accepting edge;
//   - an ERROR transfer completes 2 cycles after it.
// - Back-to-back pipelining: a read accepted in the DATA cycle of a write to the same word
//   returns the new data, because the write commits at that edge.
// - Hsel may drop during a pending data phase; the data phase still completes normally.
// - Reset mid-WAIT or mid-DATA drops the pending write; the memory word is unchanged.
// TESTING
// - WS=1: write word 0x10 = 0xCAFEBABE, then read 0x10.
//   -> Hreadyout low exactly 1 cycle per transfer; read Hrdata=0xCAFEBABE, Hresp=00.
// - Byte write Hsize=0 to 0x13 with Hwdata=0xAB000000, then word read 0x10.
//   -> 0xABFEBABE; halfword write to 0x12 with 0x12340000 -> 0x1234BABE.
// - Read at Haddr=MEM_DEPTH*4 (0x400), and a halfword access to 0x11.
//   -> cycle 1: Hreadyout=0, Hresp=01; cycle 2: Hreadyout=1, Hresp=01; memory unchanged.
// - WS=0, pipelined NONSEQ/SEQ writes to 0x0,0x4,0x8 followed by reads of the same addresses.
//   -> one transfer per cycle, Hreadyout stays 1, data read back matches.
// - IDLE/BUSY with Hsel=1, and NONSEQ with Hsel=1 while Hready=0.
//   -> no state change, Hreadyout=1, Hresp=00, Hrdata=0, memory untouched.
// - WS=3: assert Hresetn=0 during the second WAIT cycle of a write to 0x20.
//   -> outputs go to reset values immediately; a later read of 0x20 returns its prior value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with byte-lane writes, wait states and two-cycle ERROR
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  Hsel,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [1:0]            Htrans,
  input  logic                  Hwrite,
  input  logic [2:0]            Hsize,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic                  Hready,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic [1:0]            Hresp,
  output logic                  Hreadyout
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [IW-1:0]         r_idx;
  logic [1:0]            r_lane;
  logic [1:0]            r_size;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_open;
  logic                  w_accept;
  logic                  w_illegal;
  logic [3:0]            w_be;

  assign w_word    = Haddr >> 2;
  // Only states that present Hreadyout=1 can own an address phase.
  assign w_open    = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept  = w_open && Hsel && Hready && ((Htrans == 2'b10) || (Htrans == 2'b11));
  assign w_illegal = (Hsize > 3'd2) ||
                     (w_word >= ADDR_WIDTH'(MEM_DEPTH)) ||
                     ((Hsize == 3'd1) && Haddr[0]) ||
                     ((Hsize == 3'd2) && (Haddr[1:0] != 2'b00));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_lane  <= 2'd0;
      r_size  <= 2'd0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx   <= w_word[IW-1:0];
        r_lane  <= Haddr[1:0];
        r_size  <= Hsize[1:0];
        r_write <= Hwrite;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    Hreadyout  = 1'b1;
    Hresp      = 2'b00;
    Hrdata     = '0;
    case (r_state)
      S_WAIT: begin
        Hreadyout  = 1'b0;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_DATA;
      end
      S_DATA: begin
        w_next = S_IDLE;
        if (!r_write) Hrdata = r_mem[r_idx];
      end
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
        w_next    = S_ERR2;
      end
      S_ERR2: begin
        Hresp  = 2'b01;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_accept) begin
      if (w_illegal) begin
        w_next = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        w_next     = S_WAIT;
        w_cnt_next = 4'(WAIT_STATES);
      end else begin
        w_next = S_DATA;
      end
    end
  end

  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Commit is gated by the async-reset state, so a reset in DATA drops the write.
  always_ff @(posedge Hclk) begin
    if ((r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= Hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized AHB master against a word-array model, WS=0/1/3 instances
module tb_ahb_sram_slave;

  localparam int WS_OF [3] = '{0, 1, 3};

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        Hclk;
  logic        Hresetn;
  logic [2:0]  sel_s, write_s, force_low, readyout, hready;
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [1:0]  trans_s [3];
  logic [2:0]  size_s  [3];
  logic [31:0] rdata   [3];
  logic [1:0]  resp    [3];

  logic [31:0] mdl [3][256];
  logic [31:0] last_rdata;
  xfer_t       q[$];
  int          n_tests, n_fail;

  assign hready = readyout & ~force_low;

  ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel_s[0]), .Haddr(addr_s[0]), .Htrans(trans_s[0]),
    .Hwrite(write_s[0]), .Hsize(size_s[0]), .Hwdata(wdata_s[0]), .Hready(hready[0]),
    .Hrdata(rdata[0]), .Hresp(resp[0]), .Hreadyout(readyout[0]));
  ahb_sram_slave #(.WAIT_STATES(1)) u_ws1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel_s[1]), .Haddr(addr_s[1]), .Htrans(trans_s[1]),
    .Hwrite(write_s[1]), .Hsize(size_s[1]), .Hwdata(wdata_s[1]), .Hready(hready[1]),
    .Hrdata(rdata[1]), .Hresp(resp[1]), .Hreadyout(readyout[1]));
  ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel_s[2]), .Haddr(addr_s[2]), .Htrans(trans_s[2]),
    .Hwrite(write_s[2]), .Hsize(size_s[2]), .Hwdata(wdata_s[2]), .Hready(hready[2]),
    .Hrdata(rdata[2]), .Hresp(resp[2]), .Hreadyout(readyout[2]));

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic xfer_t idle_x();
    xfer_t x;
    x = '0;
    return x;
  endfunction

  function automatic bit illegal(input xfer_t x);
    return (x.size > 3'd2) || ((x.addr >> 2) >= 32'd256) ||
           ((x.size == 3'd1) && x.addr[0]) ||
           ((x.size == 3'd2) && (x.addr[1:0] != 2'b00));
  endfunction

  task automatic push(input logic s, input logic [1:0] t, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    xfer_t x;
    x.sel = s; x.trans = t; x.wr = w; x.size = sz; x.addr = a; x.wdata = wd;
    q.push_back(x);
  endtask

  task automatic drive(input int d, input xfer_t x, input logic [31:0] wd);
    sel_s[d]   = x.sel;
    trans_s[d] = x.trans;
    write_s[d] = x.wr;
    size_s[d]  = x.size;
    addr_s[d]  = x.addr;
    wdata_s[d] = wd;
  endtask

  task automatic commit(input int d, input xfer_t x);
    int w;
    bit en;
    w = int'(x.addr[9:2]);
    for (int b = 0; b < 4; b++) begin
      if (x.size == 3'd0)      en = (b == int'(x.addr[1:0]));
      else if (x.size == 3'd1) en = ((b / 2) == int'(x.addr[1]));
      else                     en = 1'b1;
      if (en) mdl[d][w][8*b +: 8] = x.wdata[8*b +: 8];
    end
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int    r, word, off;
    x.sel = ($urandom_range(0, 9) != 0);
    r = $urandom_range(0, 9);
    if (r == 0)      x.trans = 2'b00;
    else if (r == 1) x.trans = 2'b01;
    else if (r < 6)  x.trans = 2'b10;
    else             x.trans = 2'b11;
    x.wr   = 1'($urandom_range(0, 1));
    x.size = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    word   = ($urandom_range(0, 15) == 0) ? 256 + $urandom_range(0, 3) : $urandom_range(0, 15);
    if ($urandom_range(0, 7) == 0)  off = $urandom_range(0, 3);
    else if (x.size == 3'd0)        off = $urandom_range(0, 3);
    else if (x.size == 3'd1)        off = 2 * $urandom_range(0, 1);
    else                            off = 0;
    x.addr  = 32'(word * 4 + off);
    x.wdata = $urandom;
    return x;
  endfunction

  // Pipelined master: address phase of q[idx] overlaps the data phase of the previous accept.
  task automatic run_q(input int d, output int cycles);
    xfer_t       ap, dp;
    bit          dp_v;
    int          k, idx;
    logic        rdy, exp_rdy;
    logic [1:0]  rsp, exp_rsp;
    logic [31:0] rd, exp_rd;
    dp_v = 1'b0; k = 0; idx = 0; cycles = 0; dp = idle_x();
    @(posedge Hclk); #1;
    while (idx < q.size() || dp_v) begin
      ap = (idx < q.size()) ? q[idx] : idle_x();
      drive(d, ap, dp.wdata);
      @(negedge Hclk);
      rdy = readyout[d]; rsp = resp[d]; rd = rdata[d];
      exp_rdy = 1'b1; exp_rsp = 2'b00; exp_rd = '0;
      if (dp_v) begin
        if (illegal(dp)) begin
          exp_rdy = (k >= 1);
          exp_rsp = 2'b01;
        end else begin
          exp_rdy = (k >= WS_OF[d]);
          if (exp_rdy && !dp.wr) exp_rd = mdl[d][int'(dp.addr[9:2])];
        end
      end
      check_eq($sformatf("hreadyout[d%0d]", d), 32'(rdy), 32'(exp_rdy));
      check_eq($sformatf("hresp[d%0d]", d), 32'(rsp), 32'(exp_rsp));
      check_eq($sformatf("hrdata[d%0d]", d), rd, exp_rd);
      @(posedge Hclk);
      cycles++;
      if (rdy && !force_low[d]) begin
        if (dp_v && !illegal(dp) && dp.wr) commit(d, dp);
        if (dp_v && !illegal(dp) && !dp.wr) last_rdata = rd;
        dp_v = ap.sel && ap.trans[1];
        dp   = ap;
        k    = 0;
        if (idx < q.size()) idx++;
      end else begin
        k++;
        if (k > 20) begin
          check_eq("stall_timeout", 32'(k), 32'd0);
          break;
        end
      end
      #1;
    end
    drive(d, idle_x(), '0);
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    logic [31:0] prior;
    n_tests = 0; n_fail = 0; last_rdata = '0;
    force_low = 3'b000;
    for (int d = 0; d < 3; d++) drive(d, idle_x(), '0);
    Hresetn = 1'b0;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_ready[d%0d]", d), 32'(readyout[d]), 32'd1);
      check_eq($sformatf("rst_resp[d%0d]", d), 32'(resp[d]), 32'd0);
      check_eq($sformatf("rst_rdata[d%0d]", d), rdata[d], 32'd0);
    end
    Hresetn = 1'b1;

    // Preload the words the random traffic touches so no read sees uninitialised memory.
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) push(1'b1, 2'b10, 1'b1, 3'd2, 32'(w * 4), $urandom);
      run_q(d, c);
    end

    push(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hCAFEBABE);
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_q(1, c);
    check_eq("ws1_rd_cafebabe", last_rdata, 32'hCAFEBABE);
    check_eq("ws1_cycles", 32'(c), 32'd5);

    push(1'b1, 2'b10, 1'b1, 3'd0, 32'h13, 32'hAB000000);
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_q(1, c);
    check_eq("byte_write", last_rdata, 32'hABFEBABE);
    push(1'b1, 2'b10, 1'b1, 3'd1, 32'h12, 32'h12340000);
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_q(1, c);
    check_eq("half_write", last_rdata, 32'h1234BABE);

    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h400, 32'h0);
    push(1'b1, 2'b10, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF);
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_q(1, c);
    check_eq("err_mem_unchanged", last_rdata, 32'h1234BABE);

    push(1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'h11111111);
    push(1'b1, 2'b11, 1'b1, 3'd2, 32'h4, 32'h22222222);
    push(1'b1, 2'b11, 1'b1, 3'd2, 32'h8, 32'h33333333);
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0);
    push(1'b1, 2'b11, 1'b0, 3'd2, 32'h4, 32'h0);
    push(1'b1, 2'b11, 1'b0, 3'd2, 32'h8, 32'h0);
    run_q(0, c);
    check_eq("ws0_cycles", 32'(c), 32'd7);
    check_eq("ws0_last_rd", last_rdata, 32'h33333333);

    push(1'b1, 2'b00, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    push(1'b1, 2'b01, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    push(1'b1, 2'b01, 1'b0, 3'd2, 32'h10, 32'h0);
    run_q(1, c);
    @(posedge Hclk); #1;
    force_low[1] = 1'b1;
    push(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h0);
    drive(1, q[0], 32'hDEADBEEF);
    q.delete();
    repeat (3) begin
      @(negedge Hclk);
      check_eq("hrdy_low_ready", 32'(readyout[1]), 32'd1);
      check_eq("hrdy_low_resp", 32'(resp[1]), 32'd0);
      check_eq("hrdy_low_rdata", rdata[1], 32'd0);
    end
    drive(1, idle_x(), '0);
    force_low[1] = 1'b0;
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_q(1, c);
    check_eq("idle_busy_untouched", last_rdata, 32'h1234BABE);

    prior = mdl[2][8];
    @(posedge Hclk); #1;
    push(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h0);
    drive(2, q[0], '0);
    q.delete();
    @(posedge Hclk); #1;
    drive(2, idle_x(), 32'h5A5A5A5A);
    @(posedge Hclk); #1;
    check_eq("ws3_in_wait", 32'(readyout[2]), 32'd0);
    Hresetn = 1'b0;
    #1;
    check_eq("ws3_rst_ready", 32'(readyout[2]), 32'd1);
    check_eq("ws3_rst_resp", 32'(resp[2]), 32'd0);
    check_eq("ws3_rst_rdata", rdata[2], 32'd0);
    drive(2, idle_x(), '0);
    @(negedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
    run_q(2, c);
    check_eq("ws3_write_dropped", last_rdata, prior);

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 80; i++) q.push_back(rand_xfer());
      run_q(d, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
